fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset (word-aligned).
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h0000_0013: bubble encoding (addi x0,x0,0) presented to decode.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port stall, input, 1 bit: hold PC and IF/ID register (hazard unit load-use stall).
REQ-006 The module SHALL have port flush_d, input, 1 bit: replace IF/ID contents with a bubble.
REQ-007 The module SHALL have port pc_src_e, input, 1 bit: taken branch/jump resolved in execute; redirect fetch.
REQ-008 The module SHALL have port pc_target_e, input, 32 bits: redirect target address.
REQ-009 The module SHALL have port imem_addr, output, 32 bits: instruction memory address, equal to current PC.
REQ-010 The module SHALL have port imem_ready, input, 1 bit: imem_rdata valid for imem_addr this cycle.
REQ-011 The module SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-012 The module SHALL have port pc_f, output, 32 bits: current fetch PC.
REQ-013 The module SHALL have port instr_d, output, 32 bits: registered instruction to the decode/control unit.
REQ-014 The module SHALL have port pc_d, output, 32 bits: registered PC of instr_d.
REQ-015 The module SHALL have port pc_plus4_d, output, 32 bits: registered pc_d + 4.
REQ-016 The module SHALL have port valid_d, output, 1 bit: instr_d is a real instruction (0 = bubble).

Function
REQ-017 imem_addr and pc_f SHALL be combinationally equal to the PC register.
REQ-018 PC next-state priority SHALL be: rst -> RESET_PC; else pc_src_e -> {pc_target_e[31:2],2'b00}; else stall or !imem_ready -> hold; else PC + 4.
REQ-019 pc_src_e SHALL take priority over stall for PC update (redirect never lost).
REQ-020 PC + 4 SHALL be modulo 2^32 (32'hFFFF_FFFC advances to 32'h0000_0000).
REQ-021 IF/ID next-state priority SHALL be: rst -> bubble; else flush_d or pc_src_e -> bubble; else stall -> hold; else !imem_ready -> bubble; else load {imem_rdata, PC, PC+4}, valid_d=1.
REQ-022 Bubble SHALL mean instr_d=NOP_INSTR, valid_d=0, pc_d=0, pc_plus4_d=0.
REQ-023 Fetch-to-decode latency SHALL be exactly one cycle: word fetched at PC in cycle N appears on instr_d in cycle N+1.
REQ-024 Simultaneous stall and flush_d SHALL produce a bubble; PC SHALL still hold unless pc_src_e.
REQ-025 Simultaneous pc_src_e and !imem_ready SHALL redirect the PC and insert a bubble.
REQ-026 Target bits [1:0] SHALL be silently cleared; no exception is raised.
REQ-027 The module SHALL contain no combinational path from any input to instr_d, pc_d, pc_plus4_d or valid_d.

Reset
REQ-028 While rst=1 at a rising edge, PC SHALL become RESET_PC and IF/ID SHALL become a bubble, regardless of other inputs.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard pending state; first fetch after release SHALL be RESET_PC.
REQ-030 After reset deasserts with imem_ready=1, the instruction at RESET_PC SHALL be on instr_d one cycle later.

Verification
REQ-031 Sequential fetch: reset, imem_ready=1, memory word at addr A = 32'h00A00093+A -> instr_d follows for PCs 0,4,8,12; pc_plus4_d = pc_d+4; valid_d=1.
REQ-032 Stall: assert stall for 2 cycles at PC=8 -> pc_f stays 8; instr_d/pc_d hold word from PC=4; resume fetches 8 then 12.
REQ-033 Redirect: pc_src_e=1, pc_target_e=32'h0000_0102 while stall=1 -> next pc_f=32'h0000_0100; instr_d=32'h0000_0013, valid_d=0 that cycle.
REQ-034 Memory wait: imem_ready=0 for 3 cycles at PC=16 -> pc_f holds 16, three bubbles on decode, then word at 16 with valid_d=1.
REQ-035 Wrap: force PC to 32'hFFFF_FFFC, imem_ready=1 -> next pc_f=32'h0000_0000; pc_plus4_d=32'h0000_0000.
REQ-036 Reset mid-operation: rst=1 during stall with pc_src_e=1 -> pc_f=RESET_PC, valid_d=0; after release, normal fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and its instruction store.
// The fetch stage presents an address; the memory answers with a word and a ready flag.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Decode outputs come straight from flops, so nothing reaches them combinationally.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [31:0]        pc_target_e,
  fetch_stage_if.master      imem,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic [31:0]        pc_plus4_d,
  output logic               valid_d
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        vld;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic ifid_t bubble();
    ifid_t b;
    b.instr = NOP_INSTR;
    b.pc    = 32'd0;
    b.pc4   = 32'd0;
    b.vld   = 1'b0;
    return b;
  endfunction

  logic [31:0] pc_reg_q, pc_reg_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_seq;

  assign pc_seq = pc_inc4(pc_reg_q);

  // Next PC: a resolved redirect always wins, even over a stall, so it is never lost.
  always_comb begin
    pc_reg_d = pc_reg_q;
    if (pc_src_e) begin
      pc_reg_d = word_align(pc_target_e);
    end else if (stall || !imem.imem_ready) begin
      pc_reg_d = pc_reg_q;
    end else begin
      pc_reg_d = pc_seq;
    end
  end

  // Next IF/ID: the word behind a taken redirect is wrong-path and is squashed.
  always_comb begin
    ifid_d = ifid_q;
    if (flush_d || pc_src_e) begin
      ifid_d = bubble();
    end else if (stall) begin
      ifid_d = ifid_q;
    end else if (!imem.imem_ready) begin
      ifid_d = bubble();
    end else begin
      ifid_d.instr = imem.imem_rdata;
      ifid_d.pc    = pc_reg_q;
      ifid_d.pc4   = pc_seq;
      ifid_d.vld   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg_q <= RESET_PC;
      ifid_q   <= bubble();
    end else begin
      pc_reg_q <= pc_reg_d;
      ifid_q   <= ifid_d;
    end
  end

  assign imem.imem_addr = pc_reg_q;
  assign pc_f           = pc_reg_q;
  assign instr_d        = ifid_q.instr;
  assign pc_d           = ifid_q.pc;
  assign pc_plus4_d     = ifid_q.pc4;
  assign valid_d        = ifid_q.vld;

endmodule
